// File: rtl/latent_pkg.sv
// Shared widths, FSM state type and the z adder for the latent packer.
package latent_pkg;

  localparam int LANE_W = 16;
  localparam int LANES  = 4;
  localparam int WORD_W = 64;

  typedef enum logic {S_MU, S_VAR} state_t;

  // Overflow only possible when both operands share a sign and the sum flips it
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b,
                                            input logic sat);
    logic [15:0] s;
    s = a + b;
    if (sat) begin
      if (!a[15] && !b[15] && s[15])
        s = 16'h7FFF;
      else if (a[15] && b[15] && !s[15])
        s = 16'h8000;
    end
    return s;
  endfunction

endpackage

// File: rtl/latent_fifo.sv
// Synchronous first-word-fall-through FIFO; dout shows the head entry whenever not empty.
module latent_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is accepted only when the head leaves on the same edge
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/latent_packer.sv
// Pairs mu/var core passes into z = mu + var, packs four z per 64-bit word and streams the words out.
module latent_packer
  import latent_pkg::*;
#(
  parameter int N_LATENT   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter bit SATURATE   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_done,
  input  logic        core_op_mode,
  input  logic [15:0] core_result,
  output logic        fifo_full,
  output logic [63:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        proto_err,
  output logic        overflow
);

  localparam int IDX_W = (N_LATENT > 1) ? $clog2(N_LATENT) : 1;

  state_t              state;
  state_t              state_next;
  logic                done_q;
  logic                cap;
  logic                mu_load;
  logic                z_we;
  logic                err_set;
  logic [LANE_W-1:0]   mu_reg;
  logic [LANE_W-1:0]   z;
  logic [1:0]          lane_cnt;
  logic [IDX_W-1:0]    lat_idx;
  logic                is_last;
  logic                word_done;
  logic [WORD_W-1:0]   pack_reg;
  logic [WORD_W-1:0]   pack_next;
  logic                pop;
  logic                fifo_empty;
  logic [WORD_W:0]     fifo_dout;

  // Falling edge of done marks the cycle the pass result is valid
  assign cap = done_q & ~core_done;

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_MU;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    mu_load    = 1'b0;
    z_we       = 1'b0;
    err_set    = 1'b0;
    case (state)
      S_MU: begin
        if (cap && !core_op_mode) begin
          mu_load    = 1'b1;
          state_next = S_VAR;
        end else if (cap && core_op_mode) begin
          err_set = 1'b1;
        end
      end
      S_VAR: begin
        if (cap && core_op_mode) begin
          z_we       = 1'b1;
          state_next = S_MU;
        end else if (cap && !core_op_mode) begin
          err_set = 1'b1;
          mu_load = 1'b1;
        end
      end
      default: state_next = S_MU;
    endcase
  end

  assign z         = sat_add16(mu_reg, core_result, SATURATE);
  assign is_last   = (lat_idx == IDX_W'(N_LATENT - 1));
  assign word_done = z_we & ((lane_cnt == 2'd3) | is_last);

  always_comb begin
    pack_next = pack_reg;
    pack_next[lane_cnt*LANE_W +: LANE_W] = z;
  end

  // The pack register is cleared on completion, so a short final word has zero upper lanes
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q    <= 1'b0;
      mu_reg    <= '0;
      lane_cnt  <= '0;
      lat_idx   <= '0;
      pack_reg  <= '0;
      proto_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done_q <= core_done;
      if (mu_load)
        mu_reg <= core_result;
      if (err_set)
        proto_err <= 1'b1;
      if (z_we) begin
        lane_cnt <= word_done ? 2'd0 : lane_cnt + 2'd1;
        lat_idx  <= is_last ? '0 : lat_idx + IDX_W'(1);
        pack_reg <= word_done ? '0 : pack_next;
      end
      if (word_done && fifo_full && !pop)
        overflow <= 1'b1;
    end
  end

  assign pop = m_valid & m_ready;

  latent_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (word_done),
    .din   ({is_last, pack_next}),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign m_valid = ~fifo_empty;
  assign m_data  = fifo_dout[WORD_W-1:0];
  assign m_last  = fifo_dout[WORD_W];

endmodule

// File: tb/tb_latent_packer.sv
// Directed bench: one wrapping N_LATENT=16 packer and one saturating N_LATENT=6 packer share stimulus.
module tb_latent_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_done = 1'b0;
  logic        core_op_mode = 1'b0;
  logic [15:0] core_result = '0;
  logic        m_ready = 1'b1;
  logic        toggle_en = 1'b0;

  logic        a_full, a_valid, a_last, a_err, a_ovf;
  logic [63:0] a_data;
  logic        b_full, b_valid, b_last, b_err, b_ovf;
  logic [63:0] b_data;

  logic [64:0] qa[$];
  logic [64:0] qb[$];
  logic        a_stall_q = 1'b0;
  logic [64:0] a_held = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  latent_packer #(.N_LATENT(16), .FIFO_DEPTH(4), .SATURATE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .core_done(core_done), .core_op_mode(core_op_mode),
    .core_result(core_result), .fifo_full(a_full), .m_data(a_data), .m_valid(a_valid),
    .m_ready(m_ready), .m_last(a_last), .proto_err(a_err), .overflow(a_ovf)
  );

  latent_packer #(.N_LATENT(6), .FIFO_DEPTH(4), .SATURATE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .core_done(core_done), .core_op_mode(core_op_mode),
    .core_result(core_result), .fifo_full(b_full), .m_data(b_data), .m_valid(b_valid),
    .m_ready(m_ready), .m_last(b_last), .proto_err(b_err), .overflow(b_ovf)
  );

  task automatic checkOutput(input string tag, input logic [64:0] got, input logic [64:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Collect accepted words and confirm a stalled head word does not change
  always @(posedge clk) begin
    if (rst) begin
      a_stall_q <= 1'b0;
    end else begin
      if (a_valid && m_ready) qa.push_back({a_last, a_data});
      if (b_valid && m_ready) qb.push_back({b_last, b_data});
      if (a_stall_q && a_valid)
        checkOutput("stall_hold", {a_last, a_data}, a_held);
      a_stall_q <= a_valid & ~m_ready;
      a_held    <= {a_last, a_data};
    end
  end

  task automatic tick();
    @(negedge clk);
    if (toggle_en) m_ready = ~m_ready;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    core_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic applyStimulus(input logic op, input logic [15:0] res, input int hold);
    core_op_mode = op;
    core_result  = res;
    core_done    = 1'b1;
    repeat (hold) tick();
    core_done = 1'b0;
    tick();
  endtask

  task automatic applyPair(input logic [15:0] mu, input logic [15:0] vr, input int hold);
    applyStimulus(1'b0, mu, hold);
    applyStimulus(1'b1, vr, hold);
  endtask

  task automatic checkQueue(input string tag, input int idx, input logic [64:0] exp, input bit use_b);
    if (use_b) begin
      if (idx < qb.size()) checkOutput(tag, qb[idx], exp);
      else checkOutput(tag, 65'h1_DEAD_DEAD_DEAD_DEAD, exp);
    end else begin
      if (idx < qa.size()) checkOutput(tag, qa[idx], exp);
      else checkOutput(tag, 65'h1_DEAD_DEAD_DEAD_DEAD, exp);
    end
  endtask

  initial begin
    tick();
    resetDut();
    checkOutput("rst_valid", 65'(a_valid), 65'd0);
    checkOutput("rst_data", {a_last, a_data}, 65'd0);
    checkOutput("rst_flags", {61'd0, a_full, a_err, a_ovf, b_valid}, 65'd0);

    // Test 1: four identical pairs, valid one cycle after the fourth var capture
    qa.delete(); qb.delete();
    for (int i = 0; i < 3; i++) applyPair(16'h0018, 16'h0003, 1);
    checkOutput("t1_no_valid_early", 65'(a_valid), 65'd0);
    applyPair(16'h0018, 16'h0003, 1);
    checkOutput("t1_valid_latency", 65'(a_valid), 65'd1);
    repeat (3) tick();
    checkOutput("t1_words", 65'(qa.size()), 65'd1);
    checkQueue("t1_word", 0, {1'b0, 64'h001B_001B_001B_001B}, 1'b0);

    // Test 2: short sample on the N_LATENT=6 instance
    resetDut();
    qa.delete(); qb.delete();
    for (int i = 1; i <= 6; i++) applyPair(16'(i), 16'h0000, 1);
    repeat (3) tick();
    checkOutput("t2_words", 65'(qb.size()), 65'd2);
    checkQueue("t2_word0", 0, {1'b0, 64'h0004_0003_0002_0001}, 1'b1);
    checkQueue("t2_word1", 1, {1'b1, 64'h0000_0000_0006_0005}, 1'b1);
    checkOutput("t2_lat_idx", 65'(dut_b.lat_idx), 65'd0);

    // Test 3: wrap on instance a, clamp on instance b
    resetDut();
    qa.delete(); qb.delete();
    applyPair(16'h7FF0, 16'h0020, 1);
    applyPair(16'h8000, 16'hFFFF, 1);
    applyPair(16'h0001, 16'h0001, 1);
    applyPair(16'h0002, 16'h0002, 1);
    repeat (3) tick();
    checkQueue("t3_wrap", 0, {1'b0, 64'h0004_0002_7FFF_8010}, 1'b0);
    checkQueue("t3_sat", 0, {1'b0, 64'h0004_0002_8000_7FFF}, 1'b1);

    // Test 4: back-pressure fills the FIFO, fifth word is dropped
    resetDut();
    qa.delete(); qb.delete();
    m_ready = 1'b0;
    for (int i = 1; i <= 16; i++) applyPair(16'(i), 16'h0000, 1);
    checkOutput("t4_full", 65'(a_full), 65'd1);
    checkOutput("t4_no_ovf_yet", 65'(a_ovf), 65'd0);
    for (int i = 17; i <= 20; i++) applyPair(16'(i), 16'h0000, 1);
    checkOutput("t4_ovf", 65'(a_ovf), 65'd1);
    m_ready = 1'b1;
    repeat (8) tick();
    checkOutput("t4_words", 65'(qa.size()), 65'd4);
    checkQueue("t4_w1", 0, {1'b0, 64'h0004_0003_0002_0001}, 1'b0);
    checkQueue("t4_w2", 1, {1'b0, 64'h0008_0007_0006_0005}, 1'b0);
    checkQueue("t4_w3", 2, {1'b0, 64'h000C_000B_000A_0009}, 1'b0);
    checkQueue("t4_w4", 3, {1'b1, 64'h0010_000F_000E_000D}, 1'b0);
    checkOutput("t4_full_clear", 65'(a_full), 65'd0);
    checkOutput("t4_drained", 65'(a_valid), 65'd0);

    // Test 5: ordering errors and reset mid-pair
    resetDut();
    qa.delete(); qb.delete();
    applyStimulus(1'b1, 16'h0033, 1);
    checkOutput("t5_err_var_first", 65'(a_err), 65'd1);
    checkOutput("t5_no_word", 65'(a_valid), 65'd0);
    resetDut();
    checkOutput("t5_err_cleared", 65'(a_err), 65'd0);
    applyStimulus(1'b0, 16'h0044, 1);
    resetDut();
    applyStimulus(1'b1, 16'h0055, 1);
    checkOutput("t5_err_after_rst", 65'(a_err), 65'd1);
    applyPair(16'h0005, 16'h0007, 1);
    for (int i = 0; i < 3; i++) applyPair(16'h0001, 16'h0000, 1);
    repeat (3) tick();
    checkOutput("t5_words", 65'(qa.size()), 65'd1);
    checkQueue("t5_word", 0, {1'b0, 64'h0001_0001_0001_000C}, 1'b0);

    // Test 6: long done pulses with a toggling consumer
    resetDut();
    qa.delete(); qb.delete();
    m_ready = 1'b0;
    toggle_en = 1'b1;
    for (int i = 1; i <= 8; i++) applyPair(16'h0100, 16'(i), 5);
    toggle_en = 1'b0;
    m_ready = 1'b1;
    repeat (6) tick();
    checkOutput("t6_words", 65'(qa.size()), 65'd2);
    checkQueue("t6_w0", 0, {1'b0, 64'h0104_0103_0102_0101}, 1'b0);
    checkQueue("t6_w1", 1, {1'b0, 64'h0108_0107_0106_0105}, 1'b0);
    checkOutput("t6_no_err", {63'd0, a_err, a_ovf}, 65'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
